// File: rtl/branch_resolver.sv
// Branch resolver for the MEMORY stage.
// Resolves BEQ/BNE against the fetch-time prediction and owns the 2-bit history
// counters. It is the only writer of the branch predictor table. On a
// misprediction it raises flush and presents both recovery addresses.
// Optional feature macro: BRANCH_STATS_EN enables the branch and mispredict counters.
// IDX_BITS must not exceed 8, because BPT_WRITE_ADDR is 8 bits wide.
module branch_resolver #(
  parameter int unsigned IDX_BITS  = 6,
  parameter logic [1:0]  RESET_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cache_stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_prediction,
  input  logic [31:0] BR_PC,
  input  logic [31:0] BR_TARGET,
  output logic        flush,
  output logic        branch_result,
  output logic [31:0] RECOVER_TAKEN,
  output logic [31:0] RECOVER_NOT_TAKEN,
  output logic        bpt_write_enable,
  output logic [7:0]  BPT_WRITE_ADDR,
  output logic [32:0] BPT_DATA_IN,
  output logic [31:0] BRANCH_COUNT,
  output logic [31:0] MISPREDICT_COUNT
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  typedef enum logic {StResolve, StFlush} state_t;

  state_t              state_q, state_d;
  logic [1:0]          hist_q [Entries];
  logic [IDX_BITS-1:0] idx;
  logic                accept;
  logic                mispredict;
  logic [1:0]          ctr_cur;
  logic [1:0]          ctr_next;

  assign idx        = BR_PC[IDX_BITS-1:0];
  assign accept     = br_valid & ~cache_stall & (state_q == StResolve);
  assign mispredict = br_taken ^ br_prediction;

  // Saturating update of the counter at the branch's index.
  // The history is written on the accept edge. A back-to-back branch to the
  // same index therefore reads the freshly updated value, which gives
  // read-after-write forwarding without a bypass path.
  always_comb begin
    ctr_cur  = hist_q[idx];
    ctr_next = ctr_cur;
    if (br_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  // Next-state logic. Branches arriving while in flush are wrong-path and are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StResolve: if (accept && mispredict) state_d = StFlush;
      StFlush:   if (!cache_stall) state_d = StResolve;
      default:   state_d = StResolve;
    endcase
  end

  // State register; flush is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StResolve;
      flush   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush   <= (state_d == StFlush);
    end
  end

  // History table. All entries return to RESET_CTR on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(Entries); k++) hist_q[k] <= RESET_CTR;
    end else if (accept) begin
      hist_q[idx] <= ctr_next;
    end
  end

  // Resolution outputs: the write strobe pulses per accept; the other outputs hold between accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bpt_write_enable  <= 1'b0;
      BPT_WRITE_ADDR    <= '0;
      BPT_DATA_IN       <= '0;
      branch_result     <= 1'b0;
      RECOVER_TAKEN     <= '0;
      RECOVER_NOT_TAKEN <= '0;
    end else begin
      bpt_write_enable <= accept;
      if (accept) begin
        BPT_WRITE_ADDR    <= 8'(idx);
        BPT_DATA_IN       <= {BR_TARGET, ctr_next[1]};
        branch_result     <= br_taken;
        RECOVER_TAKEN     <= BR_TARGET;
        RECOVER_NOT_TAKEN <= BR_PC + 32'd4;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Free-running statistics counters. They wrap at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BRANCH_COUNT     <= '0;
      MISPREDICT_COUNT <= '0;
    end else if (accept) begin
      BRANCH_COUNT <= BRANCH_COUNT + 32'd1;
      if (mispredict) MISPREDICT_COUNT <= MISPREDICT_COUNT + 32'd1;
    end
  end
`else
  assign BRANCH_COUNT     = '0;
  assign MISPREDICT_COUNT = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: table-driven vectors plus hand-written
// sequences for async reset mid-flush and the statistics counters.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        cache_stall, br_valid, br_taken, br_prediction;
  logic [31:0] BR_PC, BR_TARGET;
  logic        flush, branch_result, bpt_write_enable;
  logic [31:0] RECOVER_TAKEN, RECOVER_NOT_TAKEN;
  logic [7:0]  BPT_WRITE_ADDR;
  logic [32:0] BPT_DATA_IN;
  logic [31:0] BRANCH_COUNT, MISPREDICT_COUNT;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk               (clk),
    .reset             (reset),
    .cache_stall       (cache_stall),
    .br_valid          (br_valid),
    .br_taken          (br_taken),
    .br_prediction     (br_prediction),
    .BR_PC             (BR_PC),
    .BR_TARGET         (BR_TARGET),
    .flush             (flush),
    .branch_result     (branch_result),
    .RECOVER_TAKEN     (RECOVER_TAKEN),
    .RECOVER_NOT_TAKEN (RECOVER_NOT_TAKEN),
    .bpt_write_enable  (bpt_write_enable),
    .BPT_WRITE_ADDR    (BPT_WRITE_ADDR),
    .BPT_DATA_IN       (BPT_DATA_IN),
    .BRANCH_COUNT      (BRANCH_COUNT),
    .MISPREDICT_COUNT  (MISPREDICT_COUNT)
  );

  typedef struct {
    logic        v, s, t, p;
    logic [31:0] pc, tgt;
    logic        we, fl, res;
    logic [7:0]  addr;
    logic [32:0] data;
    logic [31:0] rt, rnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic v, s, t, p, input logic [31:0] pc, tgt,
                              input logic we, fl, res, input logic [7:0] addr,
                              input logic [32:0] data, input logic [31:0] rt, rnt);
    vec_t r;
    r.v = v; r.s = s; r.t = t; r.p = p; r.pc = pc; r.tgt = tgt;
    r.we = we; r.fl = fl; r.res = res; r.addr = addr; r.data = data; r.rt = rt; r.rnt = rnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Apply inputs away from the edge, clock once, then sample 1 time unit later.
  task automatic drive(input logic v, s, t, p, input logic [31:0] pc, tgt);
    br_valid = v; cache_stall = s; br_taken = t; br_prediction = p;
    BR_PC = pc; BR_TARGET = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v s t p  pc  tgt  we fl res addr data  rt  rnt
    vecs[0]  = mk(1,0,1,0, 32'h10, 32'h40,  1,1,1, 8'h10, {32'h40,1'b1},  32'h40,  32'h14);
    vecs[1]  = mk(0,0,0,0, 32'h0,  32'h0,   0,0,1, 8'h10, {32'h40,1'b1},  32'h40,  32'h14);
    vecs[2]  = mk(1,0,0,0, 32'h08, 32'h80,  1,0,0, 8'h08, {32'h80,1'b0},  32'h80,  32'h0C);
    vecs[3]  = mk(1,0,0,0, 32'h08, 32'h80,  1,0,0, 8'h08, {32'h80,1'b0},  32'h80,  32'h0C);
    vecs[4]  = mk(1,0,1,1, 32'h08, 32'h80,  1,0,1, 8'h08, {32'h80,1'b0},  32'h80,  32'h0C);
    vecs[5]  = mk(1,0,1,1, 32'h20, 32'h100, 1,0,1, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[6]  = mk(1,0,1,1, 32'h20, 32'h100, 1,0,1, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[7]  = mk(1,0,1,1, 32'h20, 32'h100, 1,0,1, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[8]  = mk(1,0,0,1, 32'h20, 32'h100, 1,1,0, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[9]  = mk(1,1,0,0, 32'h30, 32'h200, 0,1,0, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[10] = mk(1,1,0,0, 32'h30, 32'h200, 0,1,0, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[11] = mk(1,1,0,0, 32'h30, 32'h200, 0,1,0, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[12] = mk(1,0,0,0, 32'h30, 32'h200, 0,0,0, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[13] = mk(1,1,0,0, 32'h30, 32'h200, 0,0,0, 8'h20, {32'h100,1'b1}, 32'h100, 32'h24);
    vecs[14] = mk(1,0,1,1, 32'h30, 32'h200, 1,0,1, 8'h30, {32'h200,1'b1}, 32'h200, 32'h34);
    vecs[15] = mk(1,0,0,1, 32'hFFFFFFFC, 32'h0, 1,1,0, 8'h3C, {32'h0,1'b0}, 32'h0, 32'h0);

    reset = 1'b1;
    br_valid = 0; cache_stall = 0; br_taken = 0; br_prediction = 0; BR_PC = '0; BR_TARGET = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset flush", 64'(flush), 64'd0);
    chk("reset we", 64'(bpt_write_enable), 64'd0);
    chk("reset data", 64'(BPT_DATA_IN), 64'd0);
    chk("reset rnt", 64'(RECOVER_NOT_TAKEN), 64'd0);
    chk("reset bcnt", 64'(BRANCH_COUNT), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].t, vecs[i].p, vecs[i].pc, vecs[i].tgt);
      chk($sformatf("v%0d we", i),    64'(bpt_write_enable),  64'(vecs[i].we));
      chk($sformatf("v%0d flush", i), 64'(flush),             64'(vecs[i].fl));
      chk($sformatf("v%0d res", i),   64'(branch_result),     64'(vecs[i].res));
      chk($sformatf("v%0d addr", i),  64'(BPT_WRITE_ADDR),    64'(vecs[i].addr));
      chk($sformatf("v%0d data", i),  64'(BPT_DATA_IN),       64'(vecs[i].data));
      chk($sformatf("v%0d rt", i),    64'(RECOVER_TAKEN),     64'(vecs[i].rt));
      chk($sformatf("v%0d rnt", i),   64'(RECOVER_NOT_TAKEN), 64'(vecs[i].rnt));
    end

    // Flush is high after the last vector; reset must drop it without a clock edge.
    reset = 1'b1;
    #1;
    chk("async rst flush", 64'(flush), 64'd0);
    chk("async rst we", 64'(bpt_write_enable), 64'd0);
    chk("async rst rt", 64'(RECOVER_TAKEN), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // After reset, counter 0x3C must be back at 01, so a taken branch predicts 1.
    drive(1,0,1,1, 32'h3C, 32'h44);
    chk("post-rst ctr", 64'(BPT_DATA_IN), 64'({32'h44,1'b1}));
    drive(1,0,0,1, 32'h04, 32'h50);
    chk("stat mis1 flush", 64'(flush), 64'd1);
    drive(0,0,0,0, 32'h0, 32'h0);
    drive(1,0,0,0, 32'h08, 32'h60);
    drive(1,0,1,0, 32'h0C, 32'h70);
    chk("stat mis2 flush", 64'(flush), 64'd1);
    drive(0,0,0,0, 32'h0, 32'h0);
    drive(1,0,1,1, 32'h10, 32'h80);
    drive(0,0,0,0, 32'h0, 32'h0);
`ifdef BRANCH_STATS_EN
    chk("branch count", 64'(BRANCH_COUNT), 64'd5);
    chk("mispredict count", 64'(MISPREDICT_COUNT), 64'd2);
`else
    chk("branch count", 64'(BRANCH_COUNT), 64'd0);
    chk("mispredict count", 64'(MISPREDICT_COUNT), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
